// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose:
//   UART transmitter that drains the read port of a dual-clock FIFO. Everything
//   runs in the FIFO read-clock domain. One FIFO word is popped per frame and
//   sent as asynchronous serial data:
//     start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop bits (1).
//   A pop is issued only while the FIFO reports not-empty. The FIFO's one-cycle
//   registered read latency is covered by a LOAD state between the pop and the
//   start bit.
//
// Parameters:
//   CLK_FREQ_HZ  read-domain clock frequency in Hz
//   BAUD         line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (must be >= 2)
//   DATA_BITS    payload bits per frame (5..9)
//   STOP_BITS    stop bits per frame (1 or 2)
//
// Ports:
//   i_clk           in   clock (FIFO read clock)
//   i_rst_n         in   asynchronous active-low reset
//   i_en            in   transmit enable; low = no new pop, frame in flight completes
//   o_fifo_rd_en    out  FIFO pop strobe (combinational)
//   i_fifo_rd_data  in   FIFO read data, valid the cycle after o_fifo_rd_en
//   i_fifo_empty    in   FIFO empty flag (already synchronised to i_clk)
//   o_tx            out  serial line, idle high, registered
//   o_busy          out  high whenever the FSM is not IDLE
//   o_frame_done    out  one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  output logic                 o_fifo_rd_en,
  input  logic [DATA_BITS-1:0] i_fifo_rd_data,
  input  logic                 i_fifo_empty,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
  // The baud counter must reach the longest period it times, which is the
  // whole stop period when STOP_BITS = 2.
  localparam int BAUD_W       = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BIT_LAST      = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST     = BAUD_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0]  BIT_CNT_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "fifo_uart_tx: CLKS_PER_BIT = CLK_FREQ_HZ / BAUD must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $fatal(1, "fifo_uart_tx: DATA_BITS must be in 5..9");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $fatal(1, "fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t                state_reg,    state_next;
  logic [BAUD_W-1:0]     baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0]      bit_cnt_reg,  bit_cnt_next;
  logic [DATA_BITS-1:0]  shift_reg,    shift_next;
  logic                  tx_reg,       tx_next;

  logic                  pop_ok;
  logic                  bit_end;
  logic                  stop_end;

  // A pop is only legal with the enable up and data in the FIFO. Holding it
  // off during reset keeps the FIFO from losing a word while we are not able
  // to capture it.
  assign pop_ok   = i_en & ~i_fifo_empty & i_rst_n;
  assign bit_end  = (baud_cnt_reg == BIT_LAST);
  assign stop_end = (baud_cnt_reg == STOP_LAST);

  // ---------------------------------------------------------------------------
  // Process 1: state register (and datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pop_ok) begin
          state_next = ST_LOAD;
        end
      end

      // Read data arrives this cycle (registered RAM read behind the pop).
      ST_LOAD: begin
        shift_next    = i_fifo_rd_data;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
        state_next    = ST_START;
      end

      ST_START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          shift_next    = shift_reg >> 1;
          if (bit_cnt_reg == BIT_CNT_LAST) begin
            bit_cnt_next = '0;
            state_next   = ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      // The whole stop period is timed in one count so that two stop bits
      // need no extra bit counter.
      ST_STOP: begin
        if (stop_end) begin
          baud_cnt_next = '0;
          state_next    = pop_ok ? ST_LOAD : ST_IDLE;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next    = ST_IDLE;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: outputs
  // ---------------------------------------------------------------------------
  // The line register is loaded from the state being entered, so o_tx shows
  // the new bit in the first cycle of that bit's state and each bit on the
  // line lasts exactly as long as its state. The start bit therefore appears
  // two cycles after the pop (LOAD, then the register).
  always_comb begin
    o_fifo_rd_en = 1'b0;
    o_frame_done = 1'b0;
    tx_next      = 1'b1;

    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[0];
      default:  tx_next = 1'b1;
    endcase

    case (state_reg)
      ST_IDLE: begin
        o_fifo_rd_en = pop_ok;
      end
      ST_STOP: begin
        if (stop_end) begin
          o_frame_done = 1'b1;
          o_fifo_rd_en = pop_ok;
        end
      end
      default: begin
        o_fifo_rd_en = 1'b0;
      end
    endcase
  end

  assign o_busy = (state_reg != ST_IDLE);
  assign o_tx   = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 10, DATA_BITS = 8.
// Two instances: u_dut1 with STOP_BITS = 1 and u_dut2 with STOP_BITS = 2, each
// fed by its own small behavioural FIFO with a one-cycle registered read.
// Frame checks walk the line cycle by cycle from the pop and compare every
// cycle against hand-written expected bit patterns.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       en;

  logic       rd_en1, empty1, tx1, busy1, fd1;
  logic [7:0] rd_data1;
  logic       rd_en2, empty2, tx2, busy2, fd2;
  logic [7:0] rd_data2;

  fifo_uart_tx #(
    .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_fifo_rd_en(rd_en1), .i_fifo_rd_data(rd_data1), .i_fifo_empty(empty1),
    .o_tx(tx1), .o_busy(busy1), .o_frame_done(fd1)
  );

  fifo_uart_tx #(
    .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(2)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_fifo_rd_en(rd_en2), .i_fifo_rd_data(rd_data2), .i_fifo_empty(empty2),
    .o_tx(tx2), .o_busy(busy2), .o_frame_done(fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- FIFO models
  logic [7:0] mem1 [0:31];
  logic [7:0] mem2 [0:31];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  int pops1 = 0, pops2 = 0, viol = 0;

  assign empty1 = (wr1 == rd1);
  assign empty2 = (wr2 == rd2);

  initial begin
    rd_data1 = 8'h00;
    rd_data2 = 8'h00;
  end

  always @(posedge clk) begin
    if (rd_en1 && empty1) viol <= viol + 1;
    if (rd_en2 && empty2) viol <= viol + 1;
    if (rd_en1 && !empty1) begin
      rd_data1 <= mem1[rd1 % 32];
      rd1      <= rd1 + 1;
      pops1    <= pops1 + 1;
    end
    if (rd_en2 && !empty2) begin
      rd_data2 <= mem2[rd2 % 32];
      rd2      <= rd2 + 1;
      pops2    <= pops2 + 1;
    end
  end

  // ------------------------------------------------------- selected instance
  logic sel = 1'b0;
  logic tx_s, rd_s, busy_s, fd_s;
  assign tx_s   = sel ? tx2    : tx1;
  assign rd_s   = sel ? rd_en2 : rd_en1;
  assign busy_s = sel ? busy2  : busy1;
  assign fd_s   = sel ? fd2    : fd1;

  // Lengths of completed high runs on the selected line (in cycles).
  int hi_run = 0;
  int hi_runs[$];
  always @(negedge clk) begin
    if (tx_s) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) hi_runs.push_back(hi_run);
      hi_run <= 0;
    end
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push1(input logic [7:0] d);
    @(posedge clk); #1;
    mem1[wr1 % 32] = d;
    wr1++;
  endtask

  task automatic push2(input logic [7:0] d);
    @(posedge clk); #1;
    mem2[wr2 % 32] = d;
    wr2++;
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    en = v;
  endtask

  task automatic wait_pop(input string name, input int max_cycles);
    int found = 0;
    for (int k = 0; k < max_cycles && found == 0; k++) begin
      @(negedge clk);
      if (rd_s) found = 1;
    end
    check(name, found, 1);
  endtask

  // Called at the negedge of the pop cycle. Index 1 is LOAD, 2..91 are the
  // start and data bits (10 cycles each), then 10*sb stop cycles.
  task automatic run_frame(input logic [9:0] seq, input int sb, input logic exp_pop,
                           input int drop_at, input string tag);
    int n = 91 + 10 * sb;
    int bit_err[10];
    int rd_err = 0, fd_err = 0, busy_err = 0, load_err = 0;
    logic exp_tx;
    for (int b = 0; b < 10; b++) bit_err[b] = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin
        exp_tx = 1'b1;
        if (tx_s !== exp_tx) load_err++;
      end else if (i <= 91) begin
        exp_tx = seq[(i - 2) / 10];
        if (tx_s !== exp_tx) bit_err[(i - 2) / 10]++;
      end else begin
        if (tx_s !== 1'b1) bit_err[9]++;
      end
      if (rd_s !== ((i == n) ? exp_pop : 1'b0)) rd_err++;
      if (fd_s !== (i == n)) fd_err++;
      if (busy_s !== 1'b1) busy_err++;
      if (i == drop_at) en = 1'b0;
    end
    check({tag, " load-cycle line high"}, load_err, 0);
    for (int b = 0; b < 10; b++)
      check($sformatf("%s bit%0d cycles wrong", tag, b), bit_err[b], 0);
    check({tag, " pop strobe timing"}, rd_err, 0);
    check({tag, " frame_done timing"}, fd_err, 0);
    check({tag, " busy during frame"}, busy_err, 0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // line bits in send order from [0]: {stop, d7..d0, start}
  } vec_t;

  vec_t vecs[6];

  initial begin
    #400_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int got;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
    vecs[4] = '{8'h01, 10'b1_0000_0001_0};
    vecs[5] = '{8'h80, 10'b1_1000_0000_0};

    rst_n = 1'b0;
    en    = 1'b1;

    // Reset values.
    @(negedge clk);
    check("reset tx", int'(tx1), 1);
    check("reset busy", int'(busy1), 0);
    check("reset frame_done", int'(fd1), 0);
    check("reset rd_en", int'(rd_en1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      p0 = pops1;
      push1(vecs[v].data);
      wait_pop($sformatf("vec%0d pop seen", v), 20);
      $display("vec%0d: data 0x%02h popped", v, vecs[v].data);
      run_frame(vecs[v].seq, 1, 1'b0, 0, $sformatf("vec%0d", v));
      @(negedge clk);
      check($sformatf("vec%0d busy drops", v), int'(busy1), 0);
      check($sformatf("vec%0d pop count", v), pops1 - p0, 1);
    end

    // Empty FIFO with enable high.
    begin
      int bad_rd = 0, bad_tx = 0, bad_busy = 0;
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if (rd_en1 !== 1'b0) bad_rd++;
        if (tx1 !== 1'b1) bad_tx++;
        if (busy1 !== 1'b0) bad_busy++;
      end
      $display("empty fifo: 500 idle cycles observed");
      check("empty rd_en cycles", bad_rd, 0);
      check("empty tx cycles", bad_tx, 0);
      check("empty busy cycles", bad_busy, 0);
    end

    // Back-to-back 0x00 then 0xFF.
    p0 = pops1;
    hi_runs.delete();
    push1(8'h00);
    mem1[wr1 % 32] = 8'hFF;
    wr1++;
    wait_pop("b2b pop1 seen", 20);
    run_frame(10'b1_0000_0000_0, 1, 1'b1, 0, "b2b f1");
    run_frame(10'b1_1111_1111_0, 1, 1'b0, 0, "b2b f2");
    got = (hi_runs.size() > 1) ? hi_runs[1] : -1;
    $display("b2b: inter-frame high run %0d cycles", got);
    check("b2b inter-frame high", got, 11);
    check("b2b pop count", pops1 - p0, 2);

    // Enable dropped 30 cycles into a 0x3C frame with 3 more words queued.
    p0 = pops1;
    push1(8'h3C);
    mem1[wr1 % 32] = 8'h11; wr1++;
    mem1[wr1 % 32] = 8'h22; wr1++;
    mem1[wr1 % 32] = 8'h33; wr1++;
    wait_pop("en-drop pop seen", 20);
    run_frame(10'b1_0011_1100_0, 1, 1'b0, 30, "en-drop");
    @(negedge clk);
    check("en-drop busy drops", int'(busy1), 0);
    repeat (50) @(negedge clk);
    $display("en-drop: fifo level %0d after frame", wr1 - rd1);
    check("en-drop fifo level", wr1 - rd1, 3);
    check("en-drop pop count", pops1 - p0, 1);
    check("en-drop no pop while idle", int'(rd_en1), 0);

    // Reset 45 cycles into the 0x11 frame.
    set_en(1'b1);
    wait_pop("rst pop seen", 20);
    repeat (45) @(negedge clk);
    check("rst pre-reset line (d3 of 0x11)", int'(tx1), 0);
    rst_n = 1'b0;
    #1;
    $display("rst: reset asserted mid-frame, tx=%0d", tx1);
    check("rst tx high immediately", int'(tx1), 1);
    check("rst busy low immediately", int'(busy1), 0);
    check("rst rd_en held off", int'(rd_en1), 0);
    repeat (3) @(negedge clk);
    check("rst fifo level", wr1 - rd1, 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_pop("rst next pop seen", 20);
    run_frame(10'b1_0010_0010_0, 1, 1'b1, 0, "rst 0x22");
    run_frame(10'b1_0011_0011_0, 1, 1'b0, 0, "rst 0x33");
    check("rst fifo drained", wr1 - rd1, 0);

    // Two stop bits, 0x55 back-to-back.
    sel = 1'b1;
    p0 = pops2;
    hi_runs.delete();
    push2(8'h55);
    mem2[wr2 % 32] = 8'h55;
    wr2++;
    wait_pop("stop2 pop1 seen", 20);
    run_frame(10'b1_0101_0101_0, 2, 1'b1, 0, "stop2 f1");
    run_frame(10'b1_0101_0101_0, 2, 1'b0, 0, "stop2 f2");
    got = (hi_runs.size() > 5) ? hi_runs[5] : -1;
    $display("stop2: inter-frame high run %0d cycles", got);
    check("stop2 inter-frame high", got, 21);
    check("stop2 pop count", pops2 - p0, 2);
    @(negedge clk);
    check("stop2 busy drops", int'(busy2), 0);

    check("pops while empty", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
